mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock, CLK; reset SHALL be nRST, asynchronous and active-low.
REQ-002 Ports SHALL be, in this order:
- CLK  in  1  system clock
- nRST  in  1  async active-low reset
- iREN  in  1  icache read request
- iaddr  in  32  icache word address (word_t)
- iload  out  32  instruction data to icache
- iwait  out  1  icache stall; low only in the cycle iload is valid
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache address
- dstore  in  32  dcache write data
- dload  out  32  read data to dcache
- dwait  out  1  dcache stall; low only in the completing cycle
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR

Function
REQ-003 The arbiter SHALL be a registered FSM with states IDLE, IGRANT, DGRANT.
REQ-004 In IDLE, all RAM strobes SHALL be low, and iwait and dwait SHALL be high.
REQ-005 In IDLE, if dREN or dWEN is high, the next state SHALL be DGRANT; otherwise, if iREN is high, the next state SHALL be IGRANT, subject to REQ-010.
REQ-006 In DGRANT, ramREN=dREN, ramWEN=dWEN, ramaddr=daddr and ramstore=dstore.
REQ-007 In IGRANT, ramREN=1, ramWEN=0, ramaddr=iaddr and ramstore=0.
REQ-008 In either grant state with ramstate==ACCESS:
- the granted side's wait SHALL go low combinationally in that cycle;
- its load SHALL equal ramload;
- the next state SHALL be IDLE.
REQ-009 FREE, BUSY and ERROR SHALL be treated as not-complete: the grant is held and the wait stays high.
REQ-010 Starvation guard:
- A 2-bit counter SHALL increment on each completed DGRANT while iREN is high.
- The counter SHALL clear on each completed IGRANT.
- When the count equals ARB_STARVE_LIMIT (3) and iREN is high, IDLE SHALL pick IGRANT even if the dcache is requesting.
- The counter SHALL saturate and never wrap.
REQ-011 If the granted requester drops its request before ACCESS, strobes SHALL follow the request low that cycle, and the next state SHALL be IDLE with no completion.
REQ-012 dREN and dWEN both high SHALL be passed through unchanged; it is a dcache error and is not arbitrated.
REQ-013 The non-granted side's wait SHALL stay high at all times.
REQ-014 The non-granted side's load SHALL be 0.
REQ-015 Minimum latency from request (in IDLE) to wait low SHALL be 2 cycles: 1 grant cycle, plus ACCESS in the grant cycle.
REQ-016 The block SHALL NOT accept a back-to-back grant without passing through IDLE for one cycle.

Reset
REQ-017 On nRST low, the state SHALL be IDLE and the starvation counter 0, immediately and asynchronously.
REQ-018 During reset, outputs SHALL be:
- ramREN, ramWEN = 0
- ramaddr, ramstore = 0
- iwait, dwait = 1
- iload, dload = 0
REQ-019 Reset asserted mid-grant SHALL abandon the transfer, with no completion signalled.

Structure
REQ-020 word_t and ramstate_t SHALL come from cpu_types_pkg.
REQ-021 ARB_STARVE_LIMIT and arb_state_t SHALL be added to cpu_types_pkg.
REQ-022 The block SHALL be a single module with no sub-modules; the FSM and counter are in-line.

Verification
REQ-023 The bench SHALL cover:
- Icache alone: iREN=1, iaddr=0x40, RAM returns ACCESS on the 2nd grant cycle with ramload=0x8C010004 -> iwait low for exactly one cycle, iload=0x8C010004.
- Simultaneous request: iREN=1 and dREN=1 (daddr=0x100) in IDLE -> DGRANT first with ramaddr=0x100; IGRANT only after the dcache completes and one IDLE cycle.
- Write path: dWEN=1, daddr=0x200, dstore=0xDEADBEEF -> ramWEN=1 with those values; dwait low on ACCESS; iwait held high throughout.
- Starvation: dcache requests continuously with iREN=1 -> after 3 dcache completions the 4th grant is IGRANT; the counter returns to 0.
- Abort and reset: drop dREN during BUSY -> ramREN low the same cycle, IDLE next; assert nRST mid-IGRANT -> strobes 0 and waits 1 immediately.
- ERROR handling: hold ramstate=ERROR for 5 cycles -> wait stays high and grant is held; ACCESS then completes normally.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU memory-side types and arbiter constants
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

    // Dcache wins allowed back-to-back while the icache is waiting.
    localparam logic [1:0] ARB_STARVE_LIMIT = 2'd3;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache-side and RAM-side signal bundle for the memory arbiter
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    word_t     iload;
    logic      iwait;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    word_t     dload;
    logic      dwait;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    // Requesters and RAM model drive the bundle.
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
    );

    // The arbiter itself.
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/dcache to single-port RAM arbiter, dcache priority with starvation guard
module mem_arbiter
    import cpu_types_pkg::*;
(
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output word_t     iload,
    output logic      iwait,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output word_t     dload,
    output logic      dwait,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    arb_state_t r_state;
    arb_state_t w_next;
    logic [1:0] r_starve;
    logic       w_dreq;
    logic       w_i_done;
    logic       w_d_done;

    assign w_dreq = dREN | dWEN;

    // Strobes and waits follow the live request so a dropped request aborts in the same cycle.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        w_i_done = 1'b0;
        w_d_done = 1'b0;
        w_next   = r_state;

        case (r_state)
            IDLE: begin
                if (iREN && (r_starve == ARB_STARVE_LIMIT)) begin
                    w_next = IGRANT;
                end else if (w_dreq) begin
                    w_next = DGRANT;
                end else if (iREN) begin
                    w_next = IGRANT;
                end
            end

            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (!iREN) begin
                    w_next = IDLE;
                end else if (ramstate == ACCESS) begin
                    iwait    = 1'b0;
                    iload    = ramload;
                    w_i_done = 1'b1;
                    w_next   = IDLE;
                end
            end

            DGRANT: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (!w_dreq) begin
                    w_next = IDLE;
                end else if (ramstate == ACCESS) begin
                    dwait    = 1'b0;
                    dload    = ramload;
                    w_d_done = 1'b1;
                    w_next   = IDLE;
                end
            end

            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_starve <= '0;
        end else begin
            r_state <= w_next;
            if (w_i_done) begin
                r_starve <= '0;
            end else if (w_d_done && iREN && (r_starve != ARB_STARVE_LIMIT)) begin
                r_starve <= r_starve + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic CLK;
    logic nRST;
    mem_arbiter_if bus();

    mem_arbiter dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (bus.iREN),
        .iaddr    (bus.iaddr),
        .iload    (bus.iload),
        .iwait    (bus.iwait),
        .dREN     (bus.dREN),
        .dWEN     (bus.dWEN),
        .daddr    (bus.daddr),
        .dstore   (bus.dstore),
        .dload    (bus.dload),
        .dwait    (bus.dwait),
        .ramREN   (bus.ramREN),
        .ramWEN   (bus.ramWEN),
        .ramaddr  (bus.ramaddr),
        .ramstore (bus.ramstore),
        .ramload  (bus.ramload),
        .ramstate (bus.ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic      iren;
        logic      dren;
        logic      dwen;
        ramstate_t rs;
        word_t     daddr;
        logic      e_ren;
        logic      e_wen;
        logic      e_iw;
        logic      e_dw;
        logic      e_store;
        word_t     e_addr;
    } vec_t;

    vec_t vecs[$];

    localparam word_t IADDR  = 32'h0000_0040;
    localparam word_t DSTORE = 32'hDEAD_BEEF;
    localparam word_t RLOAD  = 32'h8C01_0004;

    function automatic vec_t mk(input logic iren, input logic dren, input logic dwen,
                                input ramstate_t rs, input word_t da,
                                input logic ren, input logic wen, input logic iw,
                                input logic dw, input logic st, input word_t ad);
        vec_t v;
        v.iren = iren; v.dren = dren; v.dwen = dwen; v.rs = rs; v.daddr = da;
        v.e_ren = ren; v.e_wen = wen; v.e_iw = iw; v.e_dw = dw; v.e_store = st; v.e_addr = ad;
        return v;
    endfunction

    task automatic check_all(input string tag, input logic ren, input logic wen,
                             input logic iw, input logic dw, input word_t addr,
                             input word_t store, input word_t il, input word_t dl);
        check({tag, ".ramREN"},   {31'b0, bus.ramREN}, {31'b0, ren});
        check({tag, ".ramWEN"},   {31'b0, bus.ramWEN}, {31'b0, wen});
        check({tag, ".iwait"},    {31'b0, bus.iwait},  {31'b0, iw});
        check({tag, ".dwait"},    {31'b0, bus.dwait},  {31'b0, dw});
        check({tag, ".ramaddr"},  bus.ramaddr,  addr);
        check({tag, ".ramstore"}, bus.ramstore, store);
        check({tag, ".iload"},    bus.iload,    il);
        check({tag, ".dload"},    bus.dload,    dl);
    endtask

    // Reference model: who currently owns the RAM and how many dcache wins the icache has sat through.
    int    m_owner;   // 0 nobody, 1 icache, 2 dcache
    int    m_streak;
    int    m_owner_nx;
    int    m_streak_nx;
    logic  e_ren, e_wen, e_iw, e_dw;
    word_t e_addr, e_store, e_il, e_dl;

    task automatic model_eval();
        logic dreq;
        logic done;
        dreq = bus.dREN | bus.dWEN;
        done = 1'b0;
        e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1;
        e_addr = 0; e_store = 0; e_il = 0; e_dl = 0;
        m_owner_nx  = m_owner;
        m_streak_nx = m_streak;
        if (m_owner == 0) begin
            if (bus.iREN && (m_streak >= 3 || !dreq)) m_owner_nx = 1;
            else if (dreq) m_owner_nx = 2;
        end else if (m_owner == 1) begin
            e_ren  = bus.iREN;
            e_addr = bus.iaddr;
            done   = bus.iREN && (bus.ramstate == ACCESS);
            if (done) begin
                e_iw = 0; e_il = bus.ramload; m_streak_nx = 0;
            end
            if (done || !bus.iREN) m_owner_nx = 0;
        end else begin
            e_ren   = bus.dREN;
            e_wen   = bus.dWEN;
            e_addr  = bus.daddr;
            e_store = bus.dstore;
            done    = dreq && (bus.ramstate == ACCESS);
            if (done) begin
                e_dw = 0; e_dl = bus.ramload;
                if (bus.iREN && m_streak < 3) m_streak_nx = m_streak + 1;
            end
            if (done || !dreq) m_owner_nx = 0;
        end
    endtask

    int grants[$];
    int exp_grants[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Icache alone, simultaneous request, write path, abort, ERROR hold.
        vecs.push_back(mk(0,0,0, FREE,   32'h100, 0,0,1,1,0, 32'h0));
        vecs.push_back(mk(1,0,0, FREE,   32'h100, 0,0,1,1,0, 32'h0));
        vecs.push_back(mk(1,0,0, BUSY,   32'h100, 1,0,1,1,0, IADDR));
        vecs.push_back(mk(1,0,0, ACCESS, 32'h100, 1,0,0,1,0, IADDR));
        vecs.push_back(mk(0,0,0, FREE,   32'h100, 0,0,1,1,0, 32'h0));
        vecs.push_back(mk(1,1,0, FREE,   32'h100, 0,0,1,1,0, 32'h0));
        vecs.push_back(mk(1,1,0, ACCESS, 32'h100, 1,0,1,0,1, 32'h100));
        vecs.push_back(mk(1,0,0, FREE,   32'h100, 0,0,1,1,0, 32'h0));
        vecs.push_back(mk(1,0,0, ACCESS, 32'h100, 1,0,0,1,0, IADDR));
        vecs.push_back(mk(0,0,0, FREE,   32'h100, 0,0,1,1,0, 32'h0));
        vecs.push_back(mk(0,0,1, FREE,   32'h200, 0,0,1,1,0, 32'h0));
        vecs.push_back(mk(0,0,1, BUSY,   32'h200, 0,1,1,1,1, 32'h200));
        vecs.push_back(mk(0,0,1, ACCESS, 32'h200, 0,1,1,0,1, 32'h200));
        vecs.push_back(mk(0,0,0, FREE,   32'h200, 0,0,1,1,0, 32'h0));
        vecs.push_back(mk(0,1,0, FREE,   32'h100, 0,0,1,1,0, 32'h0));
        vecs.push_back(mk(0,1,0, BUSY,   32'h100, 1,0,1,1,1, 32'h100));
        vecs.push_back(mk(0,0,0, BUSY,   32'h100, 0,0,1,1,1, 32'h100));
        vecs.push_back(mk(0,0,0, ACCESS, 32'h100, 0,0,1,1,0, 32'h0));
        vecs.push_back(mk(1,0,0, FREE,   32'h100, 0,0,1,1,0, 32'h0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(1,0,0, ERROR, 32'h100, 1,0,1,1,0, IADDR));
        vecs.push_back(mk(1,0,0, ACCESS, 32'h100, 1,0,0,1,0, IADDR));
        vecs.push_back(mk(0,0,0, FREE,   32'h100, 0,0,1,1,0, 32'h0));

        bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.iaddr = IADDR; bus.daddr = 32'h100; bus.dstore = DSTORE;
        bus.ramload = RLOAD; bus.ramstate = FREE;
        nRST = 1'b1;
        #1 nRST = 1'b0;
        #1 check_all("reset", 0, 0, 1, 1, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        foreach (vecs[r]) begin
            bus.iREN = vecs[r].iren; bus.dREN = vecs[r].dren; bus.dWEN = vecs[r].dwen;
            bus.ramstate = vecs[r].rs; bus.daddr = vecs[r].daddr;
            #1;
            check_all($sformatf("vec%0d", r), vecs[r].e_ren, vecs[r].e_wen, vecs[r].e_iw,
                      vecs[r].e_dw, vecs[r].e_addr, vecs[r].e_store ? DSTORE : 32'h0,
                      vecs[r].e_iw ? 32'h0 : RLOAD, vecs[r].e_dw ? 32'h0 : RLOAD);
            @(negedge CLK);
        end

        // Starvation: continuous dcache demand with icache waiting.
        exp_grants = '{2, 2, 2, 1, 2, 2, 2, 1};
        bus.iREN = 1; bus.dREN = 1; bus.dWEN = 0; bus.daddr = 32'h100; bus.ramstate = ACCESS;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (!bus.dwait) grants.push_back(2);
            if (!bus.iwait) grants.push_back(1);
            @(negedge CLK);
        end
        check("starve.count", grants.size(), 8);
        for (int g = 0; g < 8 && g < grants.size(); g++)
            check($sformatf("starve.grant%0d", g), grants[g], exp_grants[g]);

        // Reset mid-IGRANT.
        bus.dREN = 0; bus.iREN = 1; bus.ramstate = BUSY;
        @(negedge CLK);
        #1 check("rst.igrant_ren", {31'b0, bus.ramREN}, 32'd1);
        #2 nRST = 1'b0;
        #1 check_all("rst.mid", 0, 0, 1, 1, 32'h0, 32'h0, 32'h0, 32'h0);
        bus.ramstate = ACCESS;
        #1 check("rst.no_complete", {31'b0, bus.iwait}, 32'd1);
        @(negedge CLK);
        nRST = 1'b1; bus.iREN = 0;
        #1 check("rst.idle_after", {31'b0, bus.ramREN}, 32'd0);
        @(negedge CLK);

        // Randomized run against the reference model.
        m_owner = 0; m_streak = 0;
        for (int c = 0; c < 3000; c++) begin
            bus.iREN     = ($urandom_range(0, 3) != 0);
            bus.dREN     = ($urandom_range(0, 2) == 0);
            bus.dWEN     = ($urandom_range(0, 4) == 0);
            bus.iaddr    = $urandom;
            bus.daddr    = $urandom;
            bus.dstore   = $urandom;
            bus.ramload  = $urandom;
            bus.ramstate = ramstate_t'($urandom_range(0, 3));
            #1;
            model_eval();
            check_all($sformatf("rnd%0d", c), e_ren, e_wen, e_iw, e_dw, e_addr, e_store, e_il, e_dl);
            @(posedge CLK);
            m_owner  = m_owner_nx;
            m_streak = m_streak_nx;
            @(negedge CLK);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
